ptw_mem_arbiter: RTL and testbench

- Two-requester arbiter for the single 1024-word page-table/data memory port.
- Port 0 is the page table walker's memory interface; port 1 is the core data-side (load) read interface.
- Exactly one memory transaction is outstanding at a time. The grant is held from request acceptance until the response handshake completes, so responses always route back to the originator.
- Sits between the PTW and load unit upstream and the memory model / memory controller downstream.

---
 rtl/ptw_mem_arbiter.sv | 113 +++++++++++
 tb/tb_ptw_mem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_mem_arbiter.sv
// Two-port arbiter (PTW / load) in front of a single memory port with one outstanding read.
// Default build is fixed priority (port 0 wins); define ARB_RR_EN for round-robin arbitration.
module ptw_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [ADDR_W-1:0] req0_addr_i,
    output logic              resp0_valid_o,
    input  logic              resp0_ready_i,
    output logic [DATA_W-1:0] resp0_data_o,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [ADDR_W-1:0] req1_addr_i,
    output logic              resp1_valid_o,
    input  logic              resp1_ready_i,
    output logic [DATA_W-1:0] resp1_data_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    // Handshakes: a transfer happens in a cycle where valid && ready are both 1;
    // valid never waits on ready, and the payload is held stable while valid && !ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant;
    logic              rr_ptr;
    logic [ADDR_W-1:0] addr_q;

    logic winner;
    logic req_fire;
    logic resp_fire;
    logic sel_resp_ready;

    // With no requester the winner simply rests on rr_ptr; readies are gated by valid anyway.
    always_comb begin
        winner = rr_ptr;
`ifdef ARB_RR_EN
        if (req0_valid_i && req1_valid_i) begin
            winner = rr_ptr;
        end else if (req0_valid_i) begin
            winner = 1'b0;
        end else if (req1_valid_i) begin
            winner = 1'b1;
        end
`else
        if (req0_valid_i) begin
            winner = 1'b0;
        end else if (req1_valid_i) begin
            winner = 1'b1;
        end
`endif
    end

    always_comb begin
        req0_ready_o     = (state == IDLE) && req0_valid_i && !winner;
        req1_ready_o     = (state == IDLE) && req1_valid_i && winner;
        req_fire         = req0_ready_o || req1_ready_o;
        mem_req_valid_o  = (state == ISSUE);
        mem_addr_o       = addr_q;
        sel_resp_ready   = grant ? resp1_ready_i : resp0_ready_i;
        mem_resp_ready_o = (state == WAIT) && sel_resp_ready;
        resp_fire        = mem_resp_ready_o && mem_resp_valid_i;
        resp0_valid_o    = (state == WAIT) && !grant && mem_resp_valid_i;
        resp1_valid_o    = (state == WAIT) && grant && mem_resp_valid_i;
        resp0_data_o     = mem_data_i;
        resp1_data_o     = mem_data_i;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = ISSUE;
            ISSUE:   if (mem_req_ready_i) state_nxt = WAIT;
            WAIT:    if (resp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= 1'b0;
            addr_q <= '0;
            rr_ptr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (req_fire) begin
                grant  <= winner;
                addr_q <= winner ? req1_addr_i : req0_addr_i;
            end
            // Point at the port not just served so the other side goes next on a tie.
            if (resp_fire) begin
                rr_ptr <= ~grant;
            end
        end
    end

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed bench for ptw_mem_arbiter: reset, idle, single reads, arbitration order,
// backpressure and reset while a read is outstanding.
module tb_ptw_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          req0_valid_i, req0_ready_o;
    logic [AW-1:0] req0_addr_i;
    logic          resp0_valid_o, resp0_ready_i;
    logic [DW-1:0] resp0_data_o;
    logic          req1_valid_i, req1_ready_o;
    logic [AW-1:0] req1_addr_i;
    logic          resp1_valid_o, resp1_ready_i;
    logic [DW-1:0] resp1_data_o;
    logic          mem_req_valid_o, mem_req_ready_i;
    logic [AW-1:0] mem_addr_o;
    logic          mem_resp_valid_i, mem_resp_ready_o;
    logic [DW-1:0] mem_data_i;

    int tests_run;
    int tests_failed;

    ptw_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .req0_valid_i     (req0_valid_i),
        .req0_ready_o     (req0_ready_o),
        .req0_addr_i      (req0_addr_i),
        .resp0_valid_o    (resp0_valid_o),
        .resp0_ready_i    (resp0_ready_i),
        .resp0_data_o     (resp0_data_o),
        .req1_valid_i     (req1_valid_i),
        .req1_ready_o     (req1_ready_o),
        .req1_addr_i      (req1_addr_i),
        .resp1_valid_o    (resp1_valid_o),
        .resp1_ready_i    (resp1_ready_i),
        .resp1_data_o     (resp1_data_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_data_i       (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req0_valid_i     = 1'b0;
        req0_addr_i      = '0;
        req1_valid_i     = 1'b0;
        req1_addr_i      = '0;
        resp0_ready_i    = 1'b0;
        resp1_ready_i    = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_data_i       = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        #1;
        tests_run++;
        if ({req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, mem_req_valid_o, mem_resp_ready_o} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_handshakes: got %b expected 000000",
                     {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, mem_req_valid_o, mem_resp_ready_o});
        end
        tests_run++;
        if (mem_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mem_addr: got %h expected 00000000", mem_addr_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle();
        drive_idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            tests_run++;
            if ({req0_ready_o, req1_ready_o, mem_req_valid_o, mem_resp_ready_o, resp0_valid_o, resp1_valid_o} !== 6'b0) begin
                tests_failed++;
                $display("FAIL idle_cycle_%0d: got %b expected 000000", i,
                         {req0_ready_o, req1_ready_o, mem_req_valid_o, mem_resp_ready_o, resp0_valid_o, resp1_valid_o});
            end
        end
    endtask

    task automatic test_single_port0();
        tick();
        req0_valid_i = 1'b1;
        req0_addr_i  = 32'h404;
        #1;
        tests_run++;
        if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL p0_accept: got r0=%b r1=%b mv=%b expected r0=1 r1=0 mv=0",
                     req0_ready_o, req1_ready_o, mem_req_valid_o);
        end
        tick();
        req0_valid_i    = 1'b0;
        mem_req_ready_i = 1'b1;
        #1;
        tests_run++;
        if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h404) begin
            tests_failed++;
            $display("FAIL p0_issue: got mv=%b addr=%h expected mv=1 addr=00000404", mem_req_valid_o, mem_addr_o);
        end
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_data_i       = 32'h0000_0801;
        resp0_ready_i    = 1'b1;
        #1;
        tests_run++;
        if (resp0_valid_o !== 1'b1 || resp0_data_o !== 32'h801 || resp1_valid_o !== 1'b0 || mem_resp_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL p0_resp: got v0=%b d0=%h v1=%b mrr=%b expected v0=1 d0=00000801 v1=0 mrr=1",
                     resp0_valid_o, resp0_data_o, resp1_valid_o, mem_resp_ready_o);
        end
        tick();
        mem_resp_valid_i = 1'b0;
        resp0_ready_i    = 1'b0;
        #1;
        tests_run++;
        if (resp0_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0 || mem_resp_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL p0_done: got v0=%b mv=%b mrr=%b expected 0 0 0", resp0_valid_o, mem_req_valid_o, mem_resp_ready_o);
        end
    endtask

    // Both ports request continuously; expected grant order comes from a tiny arbitration model.
    task automatic test_arbitration();
        logic          exp_rr;
        logic          exp_win;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] exp_data;
        logic          got_v0;
        logic          got_v1;
        do_reset();
        exp_rr = 1'b0;
        req0_valid_i  = 1'b1;
        req0_addr_i   = 32'h400;
        req1_valid_i  = 1'b1;
        req1_addr_i   = 32'h010;
        resp0_ready_i = 1'b1;
        resp1_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_win = exp_rr;
`else
            exp_win = 1'b0;
`endif
            exp_addr = exp_win ? 32'h010 : 32'h400;
            exp_q.push_back(32'hA000_0000 + k);
            #1;
            tests_run++;
            if (req0_ready_o !== !exp_win || req1_ready_o !== exp_win) begin
                tests_failed++;
                $display("FAIL arb_grant_%0d: got r0=%b r1=%b expected r0=%b r1=%b",
                         k, req0_ready_o, req1_ready_o, !exp_win, exp_win);
            end
            tick();
            mem_req_ready_i = 1'b1;
            #1;
            tests_run++;
            if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0 || mem_req_valid_o !== 1'b1 || mem_addr_o !== exp_addr) begin
                tests_failed++;
                $display("FAIL arb_issue_%0d: got r0=%b r1=%b mv=%b addr=%h expected 0 0 1 %h",
                         k, req0_ready_o, req1_ready_o, mem_req_valid_o, mem_addr_o, exp_addr);
            end
            tick();
            mem_req_ready_i  = 1'b0;
            exp_data         = exp_q.pop_front();
            mem_resp_valid_i = 1'b1;
            mem_data_i       = exp_data;
            #1;
            got_v0 = resp0_valid_o;
            got_v1 = resp1_valid_o;
            tests_run++;
            if (got_v0 !== !exp_win || got_v1 !== exp_win || req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0 ||
                (exp_win ? resp1_data_o : resp0_data_o) !== exp_data) begin
                tests_failed++;
                $display("FAIL arb_resp_%0d: got v0=%b v1=%b r0=%b r1=%b expected v0=%b v1=%b r0=0 r1=0 data %h",
                         k, got_v0, got_v1, req0_ready_o, req1_ready_o, !exp_win, exp_win, exp_data);
            end
            tick();
            mem_resp_valid_i = 1'b0;
            exp_rr = ~exp_win;
        end
        req0_valid_i = 1'b0;
        #1;
        tests_run++;
        if (req1_ready_o !== 1'b1 || req0_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL arb_p1_after: got r0=%b r1=%b expected r0=0 r1=1", req0_ready_o, req1_ready_o);
        end
        tick();
        req1_valid_i    = 1'b0;
        mem_req_ready_i = 1'b1;
        #1;
        tests_run++;
        if (mem_addr_o !== 32'h010 || mem_req_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL arb_p1_addr: got mv=%b addr=%h expected mv=1 addr=00000010", mem_req_valid_o, mem_addr_o);
        end
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        tick();
        drive_idle();
    endtask

    task automatic test_backpressure();
        drive_idle();
        tick();
        req1_valid_i = 1'b1;
        req1_addr_i  = 32'h010;
        #1;
        tests_run++;
        if (req1_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_accept: got r1=%b expected 1", req1_ready_o);
        end
        tick();
        req1_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h010) begin
                tests_failed++;
                $display("FAIL bp_req_hold_%0d: got mv=%b addr=%h expected mv=1 addr=00000010", i, mem_req_valid_o, mem_addr_o);
            end
            tick();
        end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_data_i       = 32'hCAFE_0010;
        resp1_ready_i    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (resp1_valid_o !== 1'b1 || resp1_data_o !== 32'hCAFE_0010 || mem_resp_ready_o !== 1'b0 || resp0_valid_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_resp_hold_%0d: got v1=%b d1=%h mrr=%b v0=%b expected 1 cafe0010 0 0",
                         i, resp1_valid_o, resp1_data_o, mem_resp_ready_o, resp0_valid_o);
            end
            tick();
        end
        resp1_ready_i = 1'b1;
        #1;
        tests_run++;
        if (mem_resp_ready_o !== 1'b1 || resp1_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_resp_release: got mrr=%b v1=%b expected 1 1", mem_resp_ready_o, resp1_valid_o);
        end
        tick();
        drive_idle();
        #1;
        tests_run++;
        if (resp1_valid_o !== 1'b0 || mem_resp_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_done: got v1=%b mrr=%b expected 0 0", resp1_valid_o, mem_resp_ready_o);
        end
    endtask

    task automatic test_reset_in_wait();
        drive_idle();
        tick();
        req1_valid_i = 1'b1;
        req1_addr_i  = 32'h020;
        tick();
        req1_valid_i    = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        resp1_ready_i   = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, mem_req_valid_o, mem_resp_ready_o} !== 6'b0 ||
            mem_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_wait_outputs: got %b addr=%h expected 000000 addr=00000000",
                     {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, mem_req_valid_o, mem_resp_ready_o}, mem_addr_o);
        end
        mem_resp_valid_i = 1'b1;
        mem_data_i       = 32'hDEAD_BEEF;
        #1;
        tests_run++;
        if (mem_resp_ready_o !== 1'b0 || resp1_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_wait_late_resp: got mrr=%b v1=%b expected 0 0", mem_resp_ready_o, resp1_valid_o);
        end
        tick();
        drive_idle();
        req0_valid_i = 1'b1;
        req0_addr_i  = 32'h404;
        #1;
        tests_run++;
        if (req0_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_wait_req0_accept: got r0=%b expected 1", req0_ready_o);
        end
        tick();
        req0_valid_i    = 1'b0;
        mem_req_ready_i = 1'b1;
        #1;
        tests_run++;
        if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h404) begin
            tests_failed++;
            $display("FAIL rst_wait_req0_issue: got mv=%b addr=%h expected mv=1 addr=00000404", mem_req_valid_o, mem_addr_o);
        end
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_data_i       = 32'h0000_1234;
        resp0_ready_i    = 1'b1;
        #1;
        tests_run++;
        if (resp0_valid_o !== 1'b1 || resp0_data_o !== 32'h1234) begin
            tests_failed++;
            $display("FAIL rst_wait_req0_resp: got v0=%b d0=%h expected 1 00001234", resp0_valid_o, resp0_data_o);
        end
        tick();
        drive_idle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        drive_idle();
        test_reset();
        test_idle();
        test_single_port0();
        test_arbitration();
        test_backpressure();
        test_reset_in_wait();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
